// File: rtl/cmos_capture_pkg.sv
// Shared state encoding and register map for the CMOS frame capture controller.
package cmos_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_STATUS     = 3'd1;
  localparam logic [2:0] REG_BUF_ADDR   = 3'd2;
  localparam logic [2:0] REG_LINE_COUNT = 3'd3;
  localparam logic [2:0] REG_LINE_WIDTH = 3'd4;
  localparam logic [2:0] REG_WORD_COUNT = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_OVERFLOW = 2;

endpackage

// File: rtl/cmos_frame_capture_ctrl_if.sv
// Avalon-MM slave, Avalon-MM write master and CMOS pixel conduit of the capture controller.
interface cmos_frame_capture_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [2:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic              irq;
  logic              cmos_frame_valid;
  logic              cmos_line_valid;
  logic [11:0]       cmos_data;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avm_waitrequest,
           cmos_frame_valid, cmos_line_valid, cmos_data,
    output avs_readdata, avm_address, avm_write, avm_writedata, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avm_waitrequest,
           cmos_frame_valid, cmos_line_valid, cmos_data,
    input  avs_readdata, avm_address, avm_write, avm_writedata, irq
  );
endinterface

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO lands only if a pop frees a slot that cycle.
module capture_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/cmos_frame_capture_ctrl.sv
// Single-frame CMOS capture: packs 12-bit pixel pairs into 32-bit words and
// writes them to memory through an Avalon-MM master, controlled over an Avalon-MM slave.
module cmos_frame_capture_ctrl
  import cmos_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input logic                      clk,
  input logic                      reset,
  cmos_frame_capture_ctrl_if.slave bus
);
  state_t            state;
  logic              fv_prev, lv_prev;
  logic              pix_odd;
  logic [11:0]       pix_hold;
  logic [15:0]       line_pix_cnt, line_width;
  logic [31:0]       line_count, word_count, buf_addr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              irq_en, done, overflow;
  logic              avm_write_r;
  logic [31:0]       avm_wdata_r, readdata_r, read_mux;

  logic        accept, line_end, frame_start, frame_end, wr_accept;
  logic        push, pop, overflow_set, fifo_full, fifo_empty, busy;
  logic        ctrl_wr, stat_wr, buf_wr;
  logic [31:0] push_data, fifo_head;

  assign busy         = (state != IDLE);
  assign accept       = (state == CAPTURE) && bus.cmos_frame_valid && bus.cmos_line_valid;
  assign line_end     = lv_prev && !bus.cmos_line_valid;
  assign frame_start  = bus.cmos_frame_valid && !fv_prev;
  assign frame_end    = fv_prev && !bus.cmos_frame_valid;
  assign wr_accept    = avm_write_r && !bus.avm_waitrequest;
  assign pop          = !fifo_empty && (!avm_write_r || wr_accept);
  assign overflow_set = push && fifo_full && !pop;
  assign ctrl_wr      = bus.avs_write && (bus.avs_address == REG_CTRL);
  assign stat_wr      = bus.avs_write && (bus.avs_address == REG_STATUS);
  assign buf_wr       = bus.avs_write && (bus.avs_address == REG_BUF_ADDR);

  // A pair completes on an accepted odd pixel; a lone even pixel is flushed at line end.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (state == CAPTURE && pix_odd) begin
      if (accept) begin
        push      = 1'b1;
        push_data = {4'h0, bus.cmos_data, 4'h0, pix_hold};
      end else if (line_end) begin
        push      = 1'b1;
        push_data = {20'h0, pix_hold};
      end
    end
  end

  capture_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fv_prev      <= 1'b0;
      lv_prev      <= 1'b0;
      pix_odd      <= 1'b0;
      pix_hold     <= '0;
      line_pix_cnt <= '0;
      line_width   <= '0;
      line_count   <= '0;
      word_count   <= '0;
      buf_addr     <= '0;
      wr_ptr       <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      avm_write_r  <= 1'b0;
      avm_wdata_r  <= '0;
    end else begin
      fv_prev <= bus.cmos_frame_valid;
      lv_prev <= bus.cmos_line_valid;

      if (ctrl_wr) irq_en   <= bus.avs_writedata[CTRL_IRQ_EN];
      if (buf_wr)  buf_addr <= {bus.avs_writedata[31:2], 2'b00};
      if (stat_wr && bus.avs_writedata[STAT_DONE])     done     <= 1'b0;
      if (stat_wr && bus.avs_writedata[STAT_OVERFLOW]) overflow <= 1'b0;
      if (overflow_set) overflow <= 1'b1;

      // Master: the held request stays untouched until accepted, then refills from the FIFO head.
      if (wr_accept) begin
        wr_ptr     <= wr_ptr + ADDR_W'(4);
        word_count <= word_count + 32'd1;
      end
      if (pop) begin
        avm_write_r <= 1'b1;
        avm_wdata_r <= fifo_head;
      end else if (wr_accept) begin
        avm_write_r <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (ctrl_wr && bus.avs_writedata[CTRL_START]) begin
            state        <= ARMED;
            line_count   <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            wr_ptr       <= ADDR_W'(buf_addr);
            pix_odd      <= 1'b0;
            line_pix_cnt <= '0;
          end
        end
        ARMED: begin
          if (frame_start) state <= CAPTURE;
        end
        CAPTURE: begin
          if (accept) begin
            if (line_pix_cnt != 16'hFFFF) line_pix_cnt <= line_pix_cnt + 16'd1;
            pix_odd  <= !pix_odd;
            if (!pix_odd) pix_hold <= bus.cmos_data;
          end
          if (line_end) begin
            line_count   <= line_count + 32'd1;
            line_width   <= line_pix_cnt;
            line_pix_cnt <= '0;
            pix_odd      <= 1'b0;
          end
          if (frame_end) state <= DRAIN;
        end
        DRAIN: begin
          // Hardware set is written last so it wins over a same-cycle W1C.
          if (fifo_empty && !avm_write_r) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_mux = '0;
    case (bus.avs_address)
      REG_CTRL:       read_mux[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: begin
        read_mux[STAT_BUSY]     = busy;
        read_mux[STAT_DONE]     = done;
        read_mux[STAT_OVERFLOW] = overflow;
      end
      REG_BUF_ADDR:   read_mux = buf_addr;
      REG_LINE_COUNT: read_mux = line_count;
      REG_LINE_WIDTH: read_mux = {16'h0, line_width};
      REG_WORD_COUNT: read_mux = word_count;
      default:        read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             readdata_r <= '0;
    else if (bus.avs_read) readdata_r <= read_mux;
  end

  assign bus.avs_readdata  = readdata_r;
  assign bus.avm_address   = wr_ptr;
  assign bus.avm_write     = avm_write_r;
  assign bus.avm_writedata = avm_wdata_r;
  assign bus.irq           = done && irq_en;
endmodule

// File: tb/tb_cmos_frame_capture_ctrl.sv
// Bench for cmos_frame_capture_ctrl: register table, scoreboarded frame captures, stall,
// overflow (second instance with a 4-entry FIFO), skipped frame, irq and mid-frame reset.
`timescale 1ns/1ps
module tb_cmos_frame_capture_ctrl;
  import cmos_capture_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic wait4;
  always #5 clk = ~clk;

  cmos_frame_capture_ctrl_if #(.ADDR_W(32)) bus ();
  cmos_frame_capture_ctrl_if #(.ADDR_W(32)) bus4 ();

  assign bus4.avs_address      = bus.avs_address;
  assign bus4.avs_read         = bus.avs_read;
  assign bus4.avs_write        = bus.avs_write;
  assign bus4.avs_writedata    = bus.avs_writedata;
  assign bus4.cmos_frame_valid = bus.cmos_frame_valid;
  assign bus4.cmos_line_valid  = bus.cmos_line_valid;
  assign bus4.cmos_data        = bus.cmos_data;
  assign bus4.avm_waitrequest  = bus.avm_waitrequest | wait4;

  cmos_frame_capture_ctrl #(.FIFO_DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  cmos_frame_capture_ctrl #(.FIFO_DEPTH(4), .ADDR_W(32)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard of expected master writes {address, data}.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t         exp_q[$];
  wr_t         exp_w;
  logic [31:0] exp_addr;
  logic [11:0] m_hold;
  bit          m_odd;

  logic        prev_stall;
  logic [31:0] prev_addr, prev_data;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_write_held", 32'(bus.avm_write), 32'd1);
        check("stall_addr_stable", bus.avm_address, prev_addr);
        check("stall_data_stable", bus.avm_writedata, prev_data);
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with empty scoreboard",
                   bus.avm_address, bus.avm_writedata);
        end else begin
          exp_w = exp_q.pop_front();
          check("wr_addr", bus.avm_address, exp_w.addr);
          check("wr_data", bus.avm_writedata, exp_w.data);
        end
      end
      prev_stall = bus.avm_write && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_data  = bus.avm_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d4);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    d  = bus.avs_readdata;
    d4 = bus4.avs_readdata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d, d4;
    reg_read(a, d, d4);
    check(name, d, exp);
  endtask

  // Drives one line of consecutive pixel values; stalls the master for pixel indices
  // [stall_from, stall_from+stall_len). With model set, expected words go to the scoreboard.
  task automatic drive_line(input int n, input logic [11:0] first, input bit model,
                            input int stall_from, input int stall_len);
    for (int i = 0; i < n; i++) begin
      bus.cmos_line_valid = 1'b1;
      bus.cmos_data       = first + 12'(i);
      bus.avm_waitrequest = (i >= stall_from) && (i < stall_from + stall_len);
      if (model) begin
        if (m_odd) begin
          exp_q.push_back({exp_addr, 4'h0, bus.cmos_data, 4'h0, m_hold});
          exp_addr += 32'd4;
          m_odd = 1'b0;
        end else begin
          m_hold = bus.cmos_data;
          m_odd  = 1'b1;
        end
      end
      tick();
    end
    bus.cmos_line_valid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    if (model && m_odd) begin
      exp_q.push_back({exp_addr, 20'h0, m_hold});
      exp_addr += 32'd4;
      m_odd = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic frame_begin();
    bus.cmos_frame_valid = 1'b1;
    tick();
    tick();
  endtask

  task automatic frame_end();
    bus.cmos_frame_valid = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    logic [31:0] s, s4;
    int k;
    for (k = 0; k < 300; k++) begin
      reg_read(REG_STATUS, s, s4);
      if (!s[STAT_BUSY] && !s4[STAT_BUSY]) break;
    end
    if (k == 300) begin
      n_checks++;
      $display("FAIL %s_timeout: busy still set after 300 status polls", name);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;
  reg_vec_t tbl[12];

  task automatic set_vec(input int i, input bit wr, input logic [2:0] a,
                         input logic [31:0] wd, input logic [31:0] ex, input string nm);
    tbl[i].wr = wr; tbl[i].addr = a; tbl[i].wdata = wd; tbl[i].exp = ex; tbl[i].name = nm;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d4;
    logic [31:0] base;

    set_vec(0,  0, REG_CTRL,       32'h0,        32'h0,    "rst_ctrl");
    set_vec(1,  0, REG_STATUS,     32'h0,        32'h0,    "rst_status");
    set_vec(2,  0, REG_BUF_ADDR,   32'h0,        32'h0,    "rst_buf_addr");
    set_vec(3,  0, REG_LINE_COUNT, 32'h0,        32'h0,    "rst_line_count");
    set_vec(4,  0, REG_LINE_WIDTH, 32'h0,        32'h0,    "rst_line_width");
    set_vec(5,  0, REG_WORD_COUNT, 32'h0,        32'h0,    "rst_word_count");
    set_vec(6,  1, REG_BUF_ADDR,   32'h0000_1003, 32'h1000, "buf_addr_low_bits");
    set_vec(7,  1, REG_CTRL,       32'h2,        32'h2,    "ctrl_irq_en_set");
    set_vec(8,  1, REG_CTRL,       32'h0,        32'h0,    "ctrl_irq_en_clr");
    set_vec(9,  1, REG_LINE_COUNT, 32'h55,       32'h0,    "line_count_ro");
    set_vec(10, 0, 3'd6,           32'h0,        32'h0,    "reg6_zero");
    set_vec(11, 1, 3'd7,           32'hFFFF_FFFF, 32'h0,   "reg7_zero");

    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    bus.avm_waitrequest = 1'b0; bus.cmos_frame_valid = 1'b0; bus.cmos_line_valid = 1'b0;
    bus.cmos_data = '0; wait4 = 1'b0; m_odd = 1'b0; m_hold = '0; exp_addr = '0;
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_avm_write", 32'(bus.avm_write), 32'd0);
    check("rst_avm_address", bus.avm_address, 32'd0);
    check("rst_avm_writedata", bus.avm_writedata, 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_readdata", bus.avs_readdata, 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].wdata);
      reg_read(tbl[i].addr, d, d4);
      check(tbl[i].name, d, tbl[i].exp);
    end

    // Two lines of four pixels, data 1..8.
    base = 32'h1000_0000;
    reg_write(REG_BUF_ADDR, base);
    exp_addr = base;
    reg_write(REG_CTRL, 32'h1);
    frame_begin();
    drive_line(4, 12'd1, 1'b1, -1, 0);
    drive_line(4, 12'd5, 1'b1, -1, 0);
    frame_end();
    wait_done("frame1");
    check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
    read_check("frame1_status", REG_STATUS, 32'h2);
    read_check("frame1_line_count", REG_LINE_COUNT, 32'd2);
    read_check("frame1_line_width", REG_LINE_WIDTH, 32'd4);
    read_check("frame1_word_count", REG_WORD_COUNT, 32'd4);

    // Odd-length line flushes a lone pixel.
    exp_addr = base;
    reg_write(REG_CTRL, 32'h1);
    frame_begin();
    drive_line(3, 12'hA, 1'b1, -1, 0);
    frame_end();
    wait_done("odd_line");
    check("odd_queue_empty", 32'(exp_q.size()), 32'd0);
    read_check("odd_line_width", REG_LINE_WIDTH, 32'd3);
    read_check("odd_word_count", REG_WORD_COUNT, 32'd2);

    // Ten-cycle stall mid-line; the 4-deep instance is stalled for the whole line.
    exp_addr = base;
    reg_write(REG_CTRL, 32'h1);
    frame_begin();
    wait4 = 1'b1;
    drive_line(12, 12'h100, 1'b1, 1, 10);
    wait4 = 1'b0;
    frame_end();
    wait_done("stall");
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    reg_read(REG_STATUS, d, d4);
    check("stall_status", d, 32'h2);
    check("fifo4_status_overflow", d4, 32'h6);
    reg_read(REG_WORD_COUNT, d, d4);
    check("stall_word_count", d, 32'd6);
    check("fifo4_word_count_lt6", 32'(d4 < 32'd6), 32'd1);
    reg_write(REG_STATUS, 32'h4);
    reg_read(REG_STATUS, d, d4);
    check("fifo4_overflow_w1c", d4, 32'h2);

    // Start while a frame is already running: that frame is skipped.
    bus.cmos_frame_valid = 1'b1;
    tick();
    exp_addr = base;
    reg_write(REG_CTRL, 32'h1);
    drive_line(4, 12'h300, 1'b0, -1, 0);
    frame_end();
    read_check("armed_busy", REG_STATUS, 32'h1);
    frame_begin();
    drive_line(2, 12'h400, 1'b1, -1, 0);
    frame_end();
    wait_done("skip");
    check("skip_queue_empty", 32'(exp_q.size()), 32'd0);
    read_check("skip_word_count", REG_WORD_COUNT, 32'd1);
    read_check("skip_line_count", REG_LINE_COUNT, 32'd1);

    // Interrupt follows done & irq_en and clears on STATUS W1C.
    exp_addr = base;
    reg_write(REG_CTRL, 32'h3);
    check("irq_low_while_busy", 32'(bus.irq), 32'd0);
    frame_begin();
    drive_line(2, 12'h500, 1'b1, -1, 0);
    frame_end();
    wait_done("irq");
    check("irq_high_on_done", 32'(bus.irq), 32'd1);
    reg_write(REG_STATUS, 32'h2);
    check("irq_cleared", 32'(bus.irq), 32'd0);
    read_check("irq_status_after_w1c", REG_STATUS, 32'h0);
    reg_write(REG_CTRL, 32'h0);

    // Reset during capture with a write held by waitrequest.
    bus.avm_waitrequest = 1'b1;
    reg_write(REG_CTRL, 32'h1);
    frame_begin();
    for (int i = 0; i < 4; i++) begin
      bus.cmos_line_valid = 1'b1;
      bus.cmos_data       = 12'h600 + 12'(i);
      tick();
    end
    check("pre_reset_write", 32'(bus.avm_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_write", 32'(bus.avm_write), 32'd0);
    check("async_reset_addr", bus.avm_address, 32'd0);
    bus.cmos_line_valid = 1'b0;
    bus.cmos_frame_valid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    read_check("post_reset_status", REG_STATUS, 32'h0);
    read_check("post_reset_word_count", REG_WORD_COUNT, 32'h0);
    base = 32'h2000_0010;
    reg_write(REG_BUF_ADDR, base);
    exp_addr = base;
    reg_write(REG_CTRL, 32'h1);
    frame_begin();
    drive_line(4, 12'h7F0, 1'b1, -1, 0);
    frame_end();
    wait_done("post_reset");
    check("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);
    read_check("post_reset_words", REG_WORD_COUNT, 32'd2);
    read_check("post_reset_done", REG_STATUS, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cmos_frame_capture_ctrl.md
Name: cmos_frame_capture_ctrl

Overview:
- Sequences single-frame capture from the 12-bit CMOS pixel stream (frame_valid/line_valid/data) into HPS DDR.
- Sits in the soc_system Qsys design between the camera conduit and the FPGA-to-SDRAM/HPS bridge.
- HPS software configures it through an Avalon-MM slave: buffer address, start, status, irq.
- Packs pixel pairs into 32-bit words, buffers them in a small FIFO, and drains them through an Avalon-MM write master.

Parameters:
- FIFO_DEPTH, 16, FIFO entries (power of two, ≥4).
- ADDR_W, 32, avm_address width.

Ports:
- clk  in  1  system clock; CMOS inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  register index.
- avs_read  in  1  slave read strobe.
- avs_write  in  1  slave write strobe.
- avs_writedata  in  32  slave write data.
- avs_readdata  out  32  slave read data, 1-cycle registered read latency.
- avm_address  out  ADDR_W  master byte address.
- avm_write  out  1  master write request.
- avm_writedata  out  32  packed pixel pair.
- avm_waitrequest  in  1  master stall.
- irq  out  1  level interrupt: done & irq_en.
- cmos_frame_valid  in  1  frame valid.
- cmos_line_valid  in  1  line valid.
- cmos_data  in  12  pixel.

Behaviour:
- Reset values: avs_readdata=0, avm_address=0, avm_write=0, avm_writedata=0, irq=0, all registers 0, FSM=IDLE. Reset mid-frame aborts immediately and the FIFO is emptied.
- Registers:
  - 0 CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (R/W).
  - 1 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 overflow (W1C).
  - 2 BUF_ADDR: R/W; low 2 bits forced 0.
  - 3 LINE_COUNT: RO.
  - 4 LINE_WIDTH: RO, pixels in last line.
  - 5 WORD_COUNT: RO, words written.
  - 6–7: read 0.
- FSM:
  - IDLE: start → ARMED. Entering ARMED clears LINE_COUNT, WORD_COUNT and done, and loads the write pointer from BUF_ADDR. Start while busy is ignored.
  - ARMED: waits for a rising edge of cmos_frame_valid (prev=0, cur=1). A frame already in progress at start is skipped.
  - CAPTURE: a pixel is accepted when frame_valid & line_valid. Falling frame_valid → DRAIN.
  - DRAIN: when the FIFO is empty and avm_write=0 → IDLE, done=1.
  - busy=1 in ARMED, CAPTURE and DRAIN.
- Packing:
  - Even pixel is held; odd pixel forms the word {4'h0,p1,4'h0,p0}.
  - On a line_valid falling edge with an odd pixel held, push {16'h0,4'h0,p0}.
  - On a line_valid falling edge: LINE_COUNT+1; LINE_WIDTH = pixel count of that line (16-bit, saturating at 0xFFFF).
- FIFO:
  - Push and pop in the same cycle are allowed when full.
  - Push when full and no pop: word dropped, overflow=1 (sticky), capture continues.
- Master:
  - When the FIFO is non-empty and avm_write=0, pop the head into avm_writedata and assert avm_write.
  - avm_address, avm_writedata and avm_write stay stable while avm_waitrequest=1.
  - On the cycle with avm_write=1 and waitrequest=0 (accepted), the write pointer advances by 4 and WORD_COUNT+1.
  - No bursts; one outstanding write at most. Back-to-back writes are allowed (re-assert the next cycle).
- Address wraps modulo 2^ADDR_W; no bounds check.
- Simultaneous events:
  - Frame end and a pending odd-pixel flush in the same cycle: the flush is pushed before the DRAIN check.
  - STATUS W1C and a hardware set of the same bit in the same cycle: set wins.

Decomposition:
- Package cmos_capture_pkg: FSM state enum (IDLE, ARMED, CAPTURE, DRAIN), register index constants, STATUS bit positions.
- Sub-module capture_fifo: synchronous show-ahead FIFO (DEPTH, WIDTH=32) with full/empty outputs.

Test Plan:
- Start, then a 2-line×4-pixel frame (data 1..8), no waitrequest → 4 writes to BUF_ADDR+0,4,8,C with data 0x00020001, 0x00040003, 0x00060005, 0x00080007; done=1; LINE_COUNT=2; LINE_WIDTH=4; WORD_COUNT=4.
- Line of 3 pixels (0xA,0xB,0xC) → words 0x000B000A then 0x0000000C.
- avm_waitrequest held high for 10 cycles mid-frame → address and data stable throughout, no lost words; with FIFO_DEPTH=4 and a 12-pixel line, overflow=1 and WORD_COUNT<6.
- Start asserted while frame_valid is already high → that frame ignored; the next frame is captured.
- irq_en=1 → irq rises with done; write STATUS=0x2 → irq=0.
- Reset asserted during CAPTURE → avm_write=0 asynchronously, busy=0; a subsequent start works normally.
